// File: rtl/mem_tile_sram_ctrl.sv
// OBI subordinate for the memory tile: drives a banked SRAM macro array and buffers responses in a 2-entry FIFO.
// Optional feature macro: MEM_TILE_SRAM_ADDR_CHECK_EN (out-of-range requests answer with err=1).
module mem_tile_sram_ctrl #(
    parameter int unsigned AddrWidth     = 48,
    parameter int unsigned DataWidth     = 512,
    parameter int unsigned IdWidth       = 4,
    parameter int unsigned SramDataWidth = 64,
    parameter int unsigned SramNumWords  = 2048,
    parameter int unsigned NumBankRows   = 4
) (
    input  logic                                            clk_i,
    input  logic                                            rst_ni,
    input  logic                                            obi_req_i,
    output logic                                            obi_gnt_o,
    input  logic [AddrWidth-1:0]                            obi_addr_i,
    input  logic                                            obi_we_i,
    input  logic [DataWidth/8-1:0]                          obi_be_i,
    input  logic [DataWidth-1:0]                            obi_wdata_i,
    input  logic [IdWidth-1:0]                              obi_aid_i,
    output logic                                            obi_rvalid_o,
    input  logic                                            obi_rready_i,
    output logic [DataWidth-1:0]                            obi_rdata_o,
    output logic [IdWidth-1:0]                              obi_rid_o,
    output logic                                            obi_err_o,
    output logic [NumBankRows*(DataWidth/SramDataWidth)-1:0] sram_req_o,
    output logic                                            sram_we_o,
    output logic [$clog2(SramNumWords)-1:0]                 sram_addr_o,
    output logic [DataWidth-1:0]                            sram_wdata_o,
    output logic [DataWidth/8-1:0]                          sram_be_o,
    input  logic [NumBankRows*DataWidth-1:0]                sram_rdata_i
);

    localparam int unsigned NumBanks      = DataWidth / SramDataWidth;
    localparam int unsigned SramAddrWidth = $clog2(SramNumWords);
    localparam int unsigned WordOffset    = $clog2(DataWidth / 8);
    localparam int unsigned SelWidth      = $clog2(NumBankRows);
    localparam int unsigned SelOffset     = WordOffset + SramAddrWidth;

    logic [SelWidth-1:0]  sel;
    logic                 out_of_range;
    logic                 handshake;

    logic                 fl_valid_q;
    logic                 fl_we_q;
    logic                 fl_err_q;
    logic [SelWidth-1:0]  fl_sel_q;
    logic [IdWidth-1:0]   fl_aid_q;
    logic [DataWidth-1:0] fl_rdata;
    logic [DataWidth-1:0] fl_data;

    logic [1:0]           fifo_cnt_q;
    logic                 fifo_rd_q;
    logic                 fifo_wr_q;
    logic [DataWidth-1:0] fifo_data_q [2];
    logic [IdWidth-1:0]   fifo_rid_q  [2];
    logic                 fifo_err_q  [2];

    logic                 fifo_empty;
    logic                 push;
    logic                 pop_fifo;
    logic                 resp_pop;
    logic [1:0]           outstanding;

    logic                 unused_addr_bits;

    assign sel         = obi_addr_i[SelOffset +: SelWidth];
    assign sram_addr_o = obi_addr_i[SelOffset-1:WordOffset];
    assign sram_we_o    = obi_we_i;
    assign sram_wdata_o = obi_wdata_i;
    assign sram_be_o    = obi_be_i;

    assign unused_addr_bits = ^{obi_addr_i[WordOffset-1:0],
                                obi_addr_i[AddrWidth-1:SelOffset+SelWidth]};

`ifdef MEM_TILE_SRAM_ADDR_CHECK_EN
    assign out_of_range = |obi_addr_i[AddrWidth-1:SelOffset+SelWidth];
`else
    assign out_of_range = 1'b0;
`endif

    // Credit: one slot per in-flight access plus buffered entries; a pop this cycle frees one.
    assign fifo_empty  = (fifo_cnt_q == 2'd0);
    assign outstanding = {1'b0, fl_valid_q} + fifo_cnt_q;
    assign resp_pop    = obi_rvalid_o && obi_rready_i;
    assign obi_gnt_o   = rst_ni && obi_req_i && ((outstanding - {1'b0, resp_pop}) < 2'd2);
    assign handshake   = obi_req_i && obi_gnt_o;

    always_comb begin
        sram_req_o = '0;
        if (handshake && !out_of_range) begin
            for (int r = 0; r < NumBankRows; r++) begin
                if (sel == SelWidth'(r)) begin
                    sram_req_o[r*NumBanks +: NumBanks] = '1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fl_valid_q <= 1'b0;
        end else begin
            fl_valid_q <= handshake;
        end
    end

    always_ff @(posedge clk_i) begin
        if (handshake) begin
            fl_sel_q <= sel;
            fl_aid_q <= obi_aid_i;
            fl_we_q  <= obi_we_i;
            fl_err_q <= out_of_range;
        end
    end

    always_comb begin
        fl_rdata = '0;
        for (int r = 0; r < NumBankRows; r++) begin
            if (fl_sel_q == SelWidth'(r)) begin
                fl_rdata = sram_rdata_i[r*DataWidth +: DataWidth];
            end
        end
    end

    assign fl_data = (fl_we_q || fl_err_q) ? '0 : fl_rdata;

    // SRAM read data is only valid this one cycle, so anything not bypassed is captured now.
    assign push     = fl_valid_q && !(fifo_empty && obi_rready_i);
    assign pop_fifo = !fifo_empty && obi_rready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fifo_cnt_q <= 2'd0;
            fifo_rd_q  <= 1'b0;
            fifo_wr_q  <= 1'b0;
        end else begin
            if (push) begin
                fifo_wr_q <= ~fifo_wr_q;
            end
            if (pop_fifo) begin
                fifo_rd_q <= ~fifo_rd_q;
            end
            case ({push, pop_fifo})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_data_q[fifo_wr_q] <= fl_data;
            fifo_rid_q[fifo_wr_q]  <= fl_aid_q;
            fifo_err_q[fifo_wr_q]  <= fl_err_q;
        end
    end

    always_comb begin
        obi_rvalid_o = 1'b0;
        obi_rdata_o  = '0;
        obi_rid_o    = '0;
        obi_err_o    = 1'b0;
        if (!fifo_empty) begin
            obi_rvalid_o = 1'b1;
            obi_rdata_o  = fifo_data_q[fifo_rd_q];
            obi_rid_o    = fifo_rid_q[fifo_rd_q];
            obi_err_o    = fifo_err_q[fifo_rd_q];
        end else if (fl_valid_q) begin
            obi_rvalid_o = 1'b1;
            obi_rdata_o  = fl_data;
            obi_rid_o    = fl_aid_q;
            obi_err_o    = fl_err_q;
        end
    end

endmodule

// File: tb/tb_mem_tile_sram_ctrl.sv
// Self-checking bench for mem_tile_sram_ctrl: transaction-level reference model plus directed literal checks.
module tb_mem_tile_sram_ctrl;

    localparam int AW  = 48;
    localparam int DW  = 512;
    localparam int IW  = 4;
    localparam int SDW = 64;
    localparam int SNW = 2048;
    localparam int NR  = 4;
    localparam int NB  = DW / SDW;
    localparam int BEW = DW / 8;
    localparam int SAW = 11;

    logic            clk    = 1'b0;
    logic            rst_n  = 1'b0;
    logic            req    = 1'b0;
    logic            we     = 1'b0;
    logic            rready = 1'b1;
    logic [AW-1:0]   addr   = '0;
    logic [BEW-1:0]  be     = '0;
    logic [DW-1:0]   wdata  = '0;
    logic [IW-1:0]   aid    = '0;
    logic            gnt;
    logic            rvalid;
    logic [DW-1:0]   rdata;
    logic [IW-1:0]   rid;
    logic            rerr;
    logic [NR*NB-1:0] s_req;
    logic            s_we;
    logic [SAW-1:0]  s_addr;
    logic [DW-1:0]   s_wdata;
    logic [BEW-1:0]  s_be;
    logic [NR*DW-1:0] s_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_tile_sram_ctrl dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .obi_req_i    (req),
        .obi_gnt_o    (gnt),
        .obi_addr_i   (addr),
        .obi_we_i     (we),
        .obi_be_i     (be),
        .obi_wdata_i  (wdata),
        .obi_aid_i    (aid),
        .obi_rvalid_o (rvalid),
        .obi_rready_i (rready),
        .obi_rdata_o  (rdata),
        .obi_rid_o    (rid),
        .obi_err_o    (rerr),
        .sram_req_o   (s_req),
        .sram_we_o    (s_we),
        .sram_addr_o  (s_addr),
        .sram_wdata_o (s_wdata),
        .sram_be_o    (s_be),
        .sram_rdata_i (s_rdata)
    );

    // SRAM macro array: per-bank chip selects, byte enables, 1-cycle read latency, garbage when idle.
    logic [DW-1:0] sram_mem [NR*SNW];
    always @(posedge clk) begin
        for (int r = 0; r < NR; r++) begin
            if (|s_req[r*NB +: NB]) begin
                if (s_we) begin
                    for (int b = 0; b < NB; b++)
                        if (s_req[r*NB+b])
                            for (int y = 0; y < SDW/8; y++)
                                if (s_be[b*(SDW/8)+y])
                                    sram_mem[r*SNW+int'(s_addr)][(b*(SDW/8)+y)*8 +: 8] <= s_wdata[(b*(SDW/8)+y)*8 +: 8];
                    s_rdata[r*DW +: DW] <= {16{$urandom}};
                end else begin
                    s_rdata[r*DW +: DW] <= sram_mem[r*SNW+int'(s_addr)];
                end
            end else begin
                s_rdata[r*DW +: DW] <= {16{$urandom}};
            end
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [DW-1:0] data;
        logic [IW-1:0] id;
        logic          err;
        logic          known;
    } resp_t;

    resp_t         exp_q[$];
    logic [DW-1:0] ref_mem [int];

    function automatic logic addr_oor(input logic [AW-1:0] a);
`ifdef MEM_TILE_SRAM_ADDR_CHECK_EN
        return (a >> 19) != 0;
`else
        return 1'b0;
`endif
    endfunction

    // Reference model: every granted request yields one in-order response visible the next cycle.
    always @(negedge clk) begin
        logic          pop;
        logic          gnt_exp;
        logic          oor;
        int            key;
        int            row;
        logic [NR*NB-1:0] req_exp;
        logic [DW-1:0] m;
        resp_t         r;
        if (!rst_n) begin
            chk("gnt_in_reset", gnt, 0);
            chk("sram_req_in_reset", s_req, 0);
            exp_q.delete();
        end else begin
            pop     = (exp_q.size() > 0) && rready;
            gnt_exp = req && ((exp_q.size() - (pop ? 1 : 0)) < 2);
            chk("gnt", gnt, gnt_exp);
            chk("rvalid", rvalid, exp_q.size() > 0);
            if (exp_q.size() > 0) begin
                chk("rid", rid, exp_q[0].id);
                chk("err", rerr, exp_q[0].err);
                if (exp_q[0].known) chk("rdata", rdata, exp_q[0].data);
            end
            req_exp = '0;
            if (gnt_exp) begin
                oor = addr_oor(addr);
                key = int'(addr[18:6]);
                row = int'(addr[18:17]);
                if (!oor) req_exp[row*NB +: NB] = '1;
                r.id  = aid;
                r.err = oor;
                r.data = '0;
                r.known = 1'b1;
                if (we) begin
                    if (!oor) begin
                        if (ref_mem.exists(key)) begin
                            m = ref_mem[key];
                            for (int y = 0; y < BEW; y++) if (be[y]) m[y*8 +: 8] = wdata[y*8 +: 8];
                            ref_mem[key] = m;
                        end else if (&be) begin
                            ref_mem[key] = wdata;
                        end
                    end
                end else if (!oor) begin
                    r.known = ref_mem.exists(key);
                    if (r.known) r.data = ref_mem[key];
                end
            end
            chk("sram_req", s_req, req_exp);
            if (pop) void'(exp_q.pop_front());
            if (gnt_exp) exp_q.push_back(r);
        end
    end

    task automatic txn(input logic [AW-1:0] a, input logic w, input logic [BEW-1:0] b,
                       input logic [DW-1:0] d, input logic [IW-1:0] id, output logic [NR*NB-1:0] cs);
        int n;
        n = 0;
        @(posedge clk); #1;
        req = 1'b1; addr = a; we = w; be = b; wdata = d; aid = id;
        @(negedge clk);
        while (!gnt && n < 50) begin
            @(negedge clk);
            n++;
        end
        cs = s_req;
        if (!gnt) chk("gnt_timeout", 0, 1);
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] v;
        for (int k = 0; k < DW/32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    logic [DW-1:0]    ones;
    logic [DW-1:0]    a5;
    logic [DW-1:0]    wd [NR];
    logic [DW-1:0]    part_exp;
    logic [NR*NB-1:0] cs;
    logic [NR*NB-1:0] row_cs;
    logic [AW-1:0]    pool [8];
    int               granted;
    int               idx;
    logic             g;

    initial begin
        ones = '1;
        a5   = {64{8'hA5}};
        part_exp = {{60{8'hFF}}, 32'h0};
        for (int r = 0; r < NR; r++) wd[r] = {64{8'(8'h11 * (r + 1))}};

        req = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_gnt", gnt, 0);
        chk("reset_rvalid", rvalid, 0);
        chk("reset_rdata", rdata, 0);
        chk("reset_rid", rid, 0);
        chk("reset_err", rerr, 0);
        chk("reset_sram_req", s_req, 0);
        @(posedge clk); #1;
        req = 1'b0;
        rst_n = 1'b1;

        txn(48'h40, 1'b1, '1, a5, 4'd3, cs);
        @(negedge clk);
        chk("wr_latency_rvalid", rvalid, 1);
        chk("wr_rid", rid, 3);
        chk("wr_err", rerr, 0);
        chk("wr_rdata_zero", rdata, 0);
        txn(48'h40, 1'b0, '0, '0, 4'd5, cs);
        @(negedge clk);
        chk("rd_latency_rvalid", rvalid, 1);
        chk("rd_rid", rid, 5);
        chk("rd_rdata", rdata, a5);

        for (int r = 0; r < NR; r++) begin
            txn(AW'(r) << 17, 1'b1, '1, wd[r], IW'(r), cs);
            row_cs = '0;
            row_cs[r*NB +: NB] = '1;
            chk("row_wr_cs", cs, row_cs);
        end
        for (int r = 0; r < NR; r++) begin
            txn(AW'(r) << 17, 1'b0, '0, '0, IW'(r + 4), cs);
            @(negedge clk);
            chk("row_rd_data", rdata, wd[r]);
        end

        txn(48'h100, 1'b1, '1, ones, 4'd1, cs);
        txn(48'h100, 1'b1, 64'h0F, '0, 4'd2, cs);
        txn(48'h100, 1'b0, '0, '0, 4'd7, cs);
        @(negedge clk);
        chk("partial_write", rdata, part_exp);

        idx = 0;
        granted = 0;
        @(posedge clk); #1;
        rready = 1'b0; req = 1'b1; we = 1'b0; addr = '0; aid = 4'd8;
        for (int c = 0; c < 40 && idx < 4; c++) begin
            @(negedge clk);
            g = gnt;
            if (c == 6) begin
                chk("bp_grants", granted, 2);
                chk("bp_rvalid_held", rvalid, 1);
                chk("bp_rid_held", rid, 8);
                chk("bp_rdata_held", rdata, wd[0]);
            end
            if (c == 7) chk("bp_gnt_on_pop", g, 1);
            @(posedge clk); #1;
            if (g) begin
                idx++;
                granted++;
                if (idx < 4) begin
                    aid = IW'(8 + idx);
                    addr = AW'(idx) << 17;
                end else begin
                    req = 1'b0;
                end
            end
            if (c == 6) rready = 1'b1;
        end
        req = 1'b0;
        rready = 1'b1;
        chk("bp_all_granted", idx, 4);
        repeat (4) @(posedge clk);

        txn(48'h80000, 1'b0, '0, '0, 4'd2, cs);
        @(negedge clk);
`ifdef MEM_TILE_SRAM_ADDR_CHECK_EN
        chk("oor_err", rerr, 1);
        chk("oor_rdata", rdata, 0);
        chk("oor_no_cs", cs, 0);
`else
        chk("alias_err", rerr, 0);
        chk("alias_rdata", rdata, wd[0]);
`endif

        @(posedge clk); #1;
        rready = 1'b0;
        txn(48'h40, 1'b0, '0, '0, 4'd9, cs);
        txn(48'h20000, 1'b0, '0, '0, 4'd10, cs);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        rready = 1'b1;
        @(negedge clk);
        chk("rst_flush_rvalid", rvalid, 0);
        txn(48'h40, 1'b0, '0, '0, 4'd6, cs);
        @(negedge clk);
        chk("post_rst_rvalid", rvalid, 1);
        chk("post_rst_rid", rid, 6);
        chk("post_rst_rdata", rdata, a5);

        pool[0] = 48'h0;      pool[1] = 48'h40;     pool[2] = 48'h20000; pool[3] = 48'h40040;
        pool[4] = 48'h60FC0;  pool[5] = 48'h1FFC0;  pool[6] = 48'h80000; pool[7] = 48'h100;
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            rst_n  = ($urandom % 200) != 0;
            req    = ($urandom % 3) != 0;
            we     = $urandom % 2;
            addr   = pool[$urandom % 8] | AW'($urandom % 64);
            be     = ($urandom % 2) ? '1 : {$urandom, $urandom};
            wdata  = rand_word();
            aid    = IW'($urandom);
            rready = ($urandom % 4) != 0;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        req = 1'b0;
        rready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_tile_sram_ctrl.md
# mem_tile_sram_ctrl

OBI subordinate controller that terminates the memory tile's request path (downstream of the ATOP resolver and OBI cut) and drives the banked SRAM macro array. It splits each wide word across `DataWidth/SramDataWidth` banks, selects one of `NumBankRows` macro rows per access, and returns the response through a 2-entry buffer. Unlike a bare SRAM shim, it honours `rready` back-pressure without losing the single-cycle SRAM read data.

## Interface
Parameters:
- `AddrWidth`, 48, OBI address width.
- `DataWidth`, 512, OBI data width. Must be a multiple of `SramDataWidth`.
- `IdWidth`, 4, OBI `aid`/`rid` width.
- `SramDataWidth`, 64, macro data width.
- `SramNumWords`, 2048, words per macro.
- `NumBankRows`, 4, macro rows. Power of two, ≥2.
- Derived:
  - `NumBanks = DataWidth/SramDataWidth` (8).
  - `SramAddrWidth = $clog2(SramNumWords)` (11).
  - `WordOffset = $clog2(DataWidth/8)` (6).
  - `SelWidth = $clog2(NumBankRows)` (2).
  - `SelOffset = WordOffset + SramAddrWidth` (17).

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset. Synchronous, active-low.
- `obi_req_i`  in  1  request valid.
- `obi_gnt_o`  out  1  request grant.
- `obi_addr_i`  in  AddrWidth  byte address.
- `obi_we_i`  in  1  write enable.
- `obi_be_i`  in  DataWidth/8  byte enables.
- `obi_wdata_i`  in  DataWidth  write data.
- `obi_aid_i`  in  IdWidth  transaction ID.
- `obi_rvalid_o`  out  1  response valid.
- `obi_rready_i`  in  1  response ready.
- `obi_rdata_o`  out  DataWidth  read data. Zero for writes.
- `obi_rid_o`  out  IdWidth  echoed `aid`.
- `obi_err_o`  out  1  error response.
- `sram_req_o`  out  NumBankRows*NumBanks  per-macro chip select. Index = row*NumBanks + bank.
- `sram_we_o`  out  1  write enable. Shared; qualified by `sram_req_o`.
- `sram_addr_o`  out  SramAddrWidth  word address. Shared.
- `sram_wdata_o`  out  DataWidth  write data. Bank i gets slice i.
- `sram_be_o`  out  DataWidth/8  byte enables. Bank i gets slice i.
- `sram_rdata_i`  in  NumBankRows*DataWidth  read data per row. Valid one cycle after the request.

## Operation
- `sram_addr_o = obi_addr_i[SelOffset-1:WordOffset]`.
- `sel = obi_addr_i[SelOffset+:SelWidth]`.
- Credit rule:
  - `outstanding` = (in-flight SRAM access ? 1 : 0) + buffer occupancy.
  - `obi_gnt_o = obi_req_i && (outstanding < 2)`, with a pop in the same cycle counted as freeing a slot.
- On handshake (`req && gnt`):
  - Assert `sram_req_o` for all NumBanks macros of row `sel`. No macros are enabled otherwise.
  - Register `sel`, `aid`, `we` and the error flag into the in-flight stage.
- In-flight stage, next cycle:
  - Reads: data `sram_rdata_i[sel_q]`.
  - Writes: data 0.
  - The response bypasses the buffer to the output when the buffer is empty and `rready`=1.
  - Otherwise it is pushed into the 2-entry FIFO. SRAM data must be captured that cycle.
- Output: `rvalid` = buffer non-empty or in-flight bypass. The oldest response is presented first.
- Responses are returned strictly in order. `rid` = the `aid` of the corresponding request.
- Simultaneous push and pop on a full buffer is legal. Occupancy is unchanged.

## Timing
- Reset values (all outputs not listed are 0 after reset):
  - `obi_gnt_o`=0 while in reset; otherwise combinational.
  - `obi_rvalid_o`=0, `obi_rdata_o`=0, `obi_rid_o`=0, `obi_err_o`=0.
  - `sram_req_o`=0.
  - FIFO empty; in-flight stage invalid.
- `gnt` depends combinationally on `req`.
- Latency with `rready`=1: `rvalid` 1 cycle after the grant cycle. Throughput is 1 transaction/cycle.
- Back-pressure with `rready`=0:
  - At most 2 grants are accepted.
  - `gnt` stays low until `rvalid && rready`.
  - The grant may re-assert in the same cycle as that pop.
- Response hold: `rvalid`/`rdata`/`rid`/`err` are stable while `rvalid && !rready`.
- Reset asserted mid-transaction: all buffered and in-flight responses are discarded. Outputs take their reset values on the next edge.

## Configuration
- `MEM_TILE_SRAM_ADDR_CHECK_EN` defined:
  - A request is out of range if the address bits at or above `SelOffset+SelWidth` are non-zero, i.e. outside 512 KiB at default parameters.
  - Out-of-range requests are granted normally but enable no macro.
  - Their response carries `err`=1 and `rdata`=0.
- Undefined:
  - Upper address bits are ignored, so addresses alias into the array.
  - `err` is tied to 0.

## Test plan
- Write `0x40`, `be`=all-ones, `wdata`=`0xA5..A5`, `aid`=3; then read `0x40` with `aid`=5 → write response `rid`=3 `err`=0; read response `rdata`=`0xA5..A5` `rid`=5; `rvalid` 1 cycle after each grant.
- Writes to `0x00000`, `0x20000`, `0x40000`, `0x60000` with distinct data; read each back → correct data per row. Only row `sel` chip-selects toggle for each access.
- Partial write `be`=`0x0F` on a word pre-filled with all-ones, new data zero → read returns the low 4 bytes zero, rest ones.
- Issue 4 back-to-back reads with `rready`=0 → exactly 2 grants; `rvalid` and `rdata` stable. Release `rready` → remaining reads granted; all 4 returned in order with correct `rid`s.
- Read `0x80000` → with `MEM_TILE_SRAM_ADDR_CHECK_EN`: `err`=1, `rdata`=0, no `sram_req_o` bit set. Without it: aliases to `0x00000` data, `err`=0.
- Assert `rst_ni`=0 with 2 responses buffered → next cycle `rvalid`=0. After release, a new read completes with 1-cycle latency.
